// File: rtl/mmc_spi_pkg.sv
// Shared types and constants for the MMC/SD SPI initiator: FSM state encoding,
// SPI mode constants and the divider-counter width helper.
package mmc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    // SPI mode 0, MSB first
    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;

    // Bits needed to hold a half-period reload value; never narrower than one bit
    function automatic int div_cnt_width(input int div);
        int w;
        w = $clog2(div + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mmc_spi_if.sv
// Host-side byte handshake of the MMC SPI initiator (disk controller <-> SPI engine).
interface mmc_spi_if;
    logic       start;
    logic [7:0] tx_data;
    logic       cs_assert;
    logic       slow;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    modport master (
        output start, tx_data, cs_assert, slow,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, cs_assert, slow,
        output busy, done, rx_data
    );
endinterface

// File: rtl/mmc_spi_clkdiv.sv
// SCLK half-period tick generator: down-counter reloaded with the fast or slow
// divisor, tick while the count sits at zero.
module mmc_spi_clkdiv #(
    parameter int CW          = 1,
    parameter int RELOAD_FAST = 1,
    parameter int RELOAD_SLOW = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic reload,
    input  logic sel_slow,
    output logic tick
);

    localparam logic [CW-1:0] LOAD_FAST_C = CW'(RELOAD_FAST);
    localparam logic [CW-1:0] LOAD_SLOW_C = CW'(RELOAD_SLOW);
    localparam logic [CW-1:0] ZERO_C      = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C       = CW'(1'b1);

    logic [CW-1:0] cnt_r;

    // Count down to zero and hold there until the next reload
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= ZERO_C;
        end else if (reload) begin
            cnt_r <= sel_slow ? LOAD_SLOW_C : LOAD_FAST_C;
        end else if (cnt_r != ZERO_C) begin
            cnt_r <= cnt_r - ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = (cnt_r == ZERO_C);

endmodule

// File: rtl/mmc_spi_master.sv
// Byte-oriented SPI mode-0 initiator for the emulated SD card link.
// Optional feature macro: MMC_SPI_SLOW_EN (per-byte DIV_SLOW selection for card init).
module mmc_spi_master
    import mmc_spi_pkg::*;
#(
    parameter int DIV_FAST = 1,
    parameter int DIV_SLOW = 63
) (
    input  logic         clk,
    input  logic         reset_n,
    mmc_spi_if.slave     host,
    output logic         mmc_cs,
    output logic         mmc_sclk,
    output logic         mmc_do,
    input  logic         mmc_di
);

`ifdef MMC_SPI_SLOW_EN
    localparam int CW_FAST = div_cnt_width(DIV_FAST);
    localparam int CW_SLOW = div_cnt_width(DIV_SLOW);
    localparam int CW      = (CW_FAST > CW_SLOW) ? CW_FAST : CW_SLOW;
`else
    localparam int CW      = div_cnt_width(DIV_FAST);
`endif

    spi_state_e state_r;
    logic [7:0] shift_r;
    logic [7:0] rx_data_r;
    logic [2:0] bit_cnt_r;
    logic       rx_bit_r;
    logic       busy_r;
    logic       done_r;
    logic       tick_s;
    logic       reload_s;
    logic       sel_slow_s;
    logic       accept_s;

    assign accept_s = (state_r == ST_IDLE) && host.start && !busy_r;

`ifdef MMC_SPI_SLOW_EN
    logic slow_r;

    // Divider choice is frozen at accept so slow toggles mid-byte do nothing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slow_r <= 1'b0;
        end else if (accept_s) begin
            slow_r <= host.slow;
        end else begin
            slow_r <= slow_r;
        end
    end

    // The accept cycle reloads with the live request; later reloads use the latched copy
    always_comb begin
        sel_slow_s = slow_r;
        if (state_r == ST_IDLE) begin
            sel_slow_s = host.slow;
        end else begin
            sel_slow_s = slow_r;
        end
    end
`else
    logic unused_slow_s;
    assign unused_slow_s = host.slow;
    assign sel_slow_s    = 1'b0;
`endif

    // Reload the divider whenever the FSM enters LO or HI
    always_comb begin
        reload_s = 1'b0;
        case (state_r)
            ST_IDLE: reload_s = accept_s;
            ST_LO:   reload_s = tick_s;
            ST_HI:   reload_s = tick_s && (bit_cnt_r != 3'd0);
            ST_DONE: reload_s = 1'b0;
            default: reload_s = 1'b0;
        endcase
    end

    // Without MMC_SPI_SLOW_EN the slow reload value is never selected
    mmc_spi_clkdiv #(
        .CW          (CW),
        .RELOAD_FAST (DIV_FAST),
        .RELOAD_SLOW (DIV_SLOW)
    ) u_clkdiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .reload   (reload_s),
        .sel_slow (sel_slow_s),
        .tick     (tick_s)
    );

    // Byte transfer FSM; all pin and handshake outputs are registered here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            rx_data_r <= 8'h00;
            bit_cnt_r <= 3'd0;
            rx_bit_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            mmc_cs    <= 1'b1;
            mmc_sclk  <= SPI_CPOL;
            mmc_do    <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Chip select only follows the host between bytes
                    mmc_cs <= ~host.cs_assert;
                    if (accept_s) begin
                        shift_r   <= host.tx_data;
                        bit_cnt_r <= 3'd7;
                        mmc_do    <= host.tx_data[7];
                        busy_r    <= 1'b1;
                        state_r   <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (tick_s) begin
                        mmc_sclk <= ~SPI_CPOL;
                        rx_bit_r <= mmc_di;
                        state_r  <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (tick_s) begin
                        mmc_sclk <= SPI_CPOL;
                        shift_r  <= {shift_r[6:0], rx_bit_r};
                        if (bit_cnt_r != 3'd0) begin
                            mmc_do    <= shift_r[6];
                            bit_cnt_r <= bit_cnt_r - 3'd1;
                            state_r   <= ST_LO;
                        end else begin
                            state_r   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    rx_data_r <= shift_r;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    mmc_do    <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign host.busy    = busy_r;
    assign host.done    = done_r;
    assign host.rx_data = rx_data_r;

endmodule

// File: tb/tb_mmc_spi_master.sv
// Randomized scoreboard bench for mmc_spi_master with a loopback / SD-responder
// model on the SPI pins.
module tb_mmc_spi_master;

    localparam int DIV_FAST = 1;
    localparam int DIV_SLOW = 63;
    localparam int BUDGET   = 3000;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] mosi;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mmc_cs, mmc_sclk, mmc_do, mmc_di;

    mmc_spi_if host_if ();

    mmc_spi_master #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .host     (host_if),
        .mmc_cs   (mmc_cs),
        .mmc_sclk (mmc_sclk),
        .mmc_do   (mmc_do),
        .mmc_di   (mmc_di)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   issue_cyc = 0;
    int   done_cnt = 0;
    int   rise_total = 0, rise_base = 0;
    int   fall_total = 0, fall_base = 0;
    logic [7:0] mosi_sh = 8'h00;
    logic loopback = 1'b1;
    logic [7:0] resp_r = 8'h00;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Card side: sample MOSI on rising SCLK, advance MISO bit on falling SCLK
    always @(posedge mmc_sclk) begin
        mosi_sh    <= {mosi_sh[6:0], mmc_do};
        rise_total <= rise_total + 1;
    end
    always @(negedge mmc_sclk) fall_total <= fall_total + 1;

    assign mmc_di = loopback ? mmc_do :
                    (((fall_total - fall_base) < 8) ? resp_r[7 - (fall_total - fall_base)] : 1'b1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse pops one expected transfer
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && host_if.done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: done with no transfer outstanding (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check("rx_data", {24'h0, host_if.rx_data}, {24'h0, e.rx});
                check("mosi_bits", {24'h0, mosi_sh}, {24'h0, e.mosi});
                check("latency", cyc - issue_cyc, e.lat);
                check("sclk_rises", rise_total - rise_base, 8);
                check("busy_at_done", {31'h0, host_if.busy}, 32'd0);
            end
        end
    end

    // Call just after a rising edge; start is seen on the next edge
    task automatic issue(input logic [7:0] tx, input logic lb, input logic [7:0] resp, input logic sl);
        exp_t e;
        int   div;
`ifdef MMC_SPI_SLOW_EN
        div = sl ? DIV_SLOW : DIV_FAST;
`else
        div = DIV_FAST;
`endif
        loopback        = lb;
        resp_r          = resp;
        fall_base       = fall_total;
        rise_base       = rise_total;
        host_if.tx_data = tx;
        host_if.slow    = sl;
        host_if.start   = 1'b1;
        issue_cyc       = cyc;
        e.rx   = lb ? tx : resp;
        e.mosi = tx;
        e.lat  = 16 * (div + 1) + 2;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        host_if.start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", BUDGET);
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
        #1;
        check("done_count", done_cnt, base + 1);
    endtask

    task automatic run_byte(input logic [7:0] tx, input logic lb, input logic [7:0] resp, input logic sl);
        int base;
        @(posedge clk);
        #1;
        base = done_cnt;
        issue(tx, lb, resp, sl);
        wait_done(base);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    {31'h0, host_if.busy},   32'd0);
        check({tag, "_done"},    {31'h0, host_if.done},   32'd0);
        check({tag, "_rx_data"}, {24'h0, host_if.rx_data}, 32'd0);
        check({tag, "_cs"},      {31'h0, mmc_cs},         32'd1);
        check({tag, "_sclk"},    {31'h0, mmc_sclk},       32'd0);
        check({tag, "_do"},      {31'h0, mmc_do},         32'd1);
    endtask

    initial begin
        int   base;
        bit   cs_held, seen;
        logic [7:0] tx;

        host_if.start     = 1'b0;
        host_if.tx_data   = 8'h00;
        host_if.cs_assert = 1'b0;
        host_if.slow      = 1'b0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Loopback A5 (MOSI 1,0,1,0,0,1,0,1) and responder 3C under FF
        run_byte(8'hA5, 1'b1, 8'h00, 1'b0);
        run_byte(8'hFF, 1'b0, 8'h3C, 1'b0);
        run_byte(8'h00, 1'b0, 8'hFF, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_byte(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        end

        // Start pulse and tx_data change while busy are ignored
        @(posedge clk);
        #1;
        base = done_cnt;
        tx   = 8'($urandom);
        issue(tx, 1'b1, 8'h00, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        host_if.start   = 1'b1;
        host_if.tx_data = ~tx;
        @(posedge clk);
        #1;
        host_if.start = 1'b0;
        wait_done(base);

        // Chip select deasserted mid-byte only takes effect after done
        host_if.cs_assert = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("cs_selected", {31'h0, mmc_cs}, 32'd0);
        issue(8'h5A, 1'b0, 8'hC3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        host_if.cs_assert = 1'b0;
        cs_held = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (mmc_cs !== 1'b0) cs_held = 1'b0;
            if (host_if.done === 1'b1) seen = 1'b1;
        end
        check("cs_held_until_done", {31'h0, cs_held}, 32'd1);
        check("cs_done_seen", {31'h0, seen}, 32'd1);
        @(negedge clk);
        check("cs_released_after_done", {31'h0, mmc_cs}, 32'd1);

        // Asynchronous reset in the middle of a byte
        host_if.cs_assert = 1'b1;
        @(posedge clk);
        #1;
        issue(8'hE7, 1'b1, 8'h00, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (rise_total - rise_base >= 3) seen = 1'b1;
        end
        check("rises_before_reset", {31'h0, seen}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midbyte_reset");
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_byte(8'h81, 1'b1, 8'h00, 1'b0);
        run_byte(8'($urandom), 1'b0, 8'($urandom), 1'b0);

`ifdef MMC_SPI_SLOW_EN
        // Slow byte; toggling slow mid-byte must not change the period
        @(posedge clk);
        #1;
        base = done_cnt;
        issue(8'h96, 1'b1, 8'h00, 1'b1);
        repeat (200) @(posedge clk);
        #1;
        host_if.slow = 1'b0;
        wait_done(base);
        run_byte(8'h69, 1'b0, 8'hA3, 1'b0);
`endif

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
